// File: rtl/sample_unpacker_pkg.sv
// Shared types and constants for the mode-0 sample unpacker.
package sample_unpacker_pkg;

    typedef enum logic {
        ST_SYNC = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int unsigned SAMPLE_SET_BITS       = 12;
    localparam int unsigned WORD_BITS             = 16;
    localparam int unsigned WORDS_PER_PACKET_DFLT = 720;

endpackage

// File: rtl/sample_unpacker_bit_buffer.sv
// Bit buffer: appends 16-bit words MSB-first, drains 12-bit sample sets, flags overflow.
module bit_buffer
    import sample_unpacker_pkg::*;
#(
    parameter int unsigned BUF_BITS = 48
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [WORD_BITS-1:0]       word_i,
    output logic                       ovf_c,
    output logic                       valid_o,
    output logic [SAMPLE_SET_BITS-1:0] samples_o
);

    localparam int unsigned LVL_W    = $clog2(BUF_BITS + 1);
    localparam int unsigned SUM_W    = LVL_W + 1;
    localparam int unsigned PAD_BITS = BUF_BITS - WORD_BITS;

    logic [BUF_BITS-1:0]        buf_q, buf_d, shifted, word_ext;
    logic [LVL_W-1:0]           level_q, level_d, level_post;
    logic                       drain;
    logic                       valid_q;
    logic [SAMPLE_SET_BITS-1:0] samples_q;

    // Drain works on pre-append contents; the new word lands just below what remains.
    always_comb begin
        drain      = level_q >= LVL_W'(SAMPLE_SET_BITS);
        shifted    = drain ? (buf_q << SAMPLE_SET_BITS) : buf_q;
        level_post = drain ? (level_q - LVL_W'(SAMPLE_SET_BITS)) : level_q;
        word_ext   = {word_i, PAD_BITS'(0)} >> level_post;
        ovf_c      = push_i &&
                     ((SUM_W'(level_post) + SUM_W'(WORD_BITS)) > SUM_W'(BUF_BITS));
        buf_d      = shifted;
        level_d    = level_post;
        if (flush_i) begin
            buf_d   = '0;
            level_d = '0;
        end else if (push_i && !ovf_c) begin
            buf_d   = shifted | word_ext;
            level_d = level_post + LVL_W'(WORD_BITS);
        end
    end

    // Output register mirrors the set that is drained during the following cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            buf_q     <= '0;
            level_q   <= '0;
            valid_q   <= 1'b0;
            samples_q <= '0;
        end else begin
            buf_q     <= buf_d;
            level_q   <= level_d;
            valid_q   <= level_d >= LVL_W'(SAMPLE_SET_BITS);
            samples_q <= buf_d[BUF_BITS-1 -: SAMPLE_SET_BITS];
        end
    end

    assign valid_o   = valid_q;
    assign samples_o = samples_q;

endmodule

// File: rtl/sample_unpacker.sv
// Mode-0 word stream to sample-set unpacker with packet framing and sticky error flags.
// Optional SAMPLE_UNPACKER_STATS_EN adds packet and sample counters.
module sample_unpacker
    import sample_unpacker_pkg::*;
#(
    parameter int unsigned WORDS_PER_PACKET = WORDS_PER_PACKET_DFLT,
    parameter int unsigned BUF_BITS         = 48
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [WORD_BITS-1:0]       in_data,
    input  logic                       in_en,
    input  logic                       in_packet_end,
    input  logic                       err_clear,
    output logic                       out_valid,
    output logic [SAMPLE_SET_BITS-1:0] out_samples,
    output logic                       synced,
    output logic                       frame_err,
    output logic                       ovf_err
`ifdef SAMPLE_UNPACKER_STATS_EN
    ,
    output logic [15:0]                packet_count,
    output logic [31:0]                sample_count
`endif
);

    localparam int unsigned CNT_W = $clog2(WORDS_PER_PACKET);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS_PER_PACKET - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             flush, push, frame_set, ovf_c;
    logic             synced_q, frame_err_q, ovf_err_q;
`ifdef SAMPLE_UNPACKER_STATS_EN
    logic             pkt_ok;
    logic [15:0]      pkt_cnt_q;
    logic [31:0]      smp_cnt_q;
`endif

    // Framing FSM: SYNC discards and flushes until a packet end; RUN counts words.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        flush     = 1'b0;
        push      = 1'b0;
        frame_set = 1'b0;
`ifdef SAMPLE_UNPACKER_STATS_EN
        pkt_ok    = 1'b0;
`endif
        case (state_q)
            ST_SYNC: begin
                flush = 1'b1;
                if (in_en && in_packet_end) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                if (in_en) begin
                    if (in_packet_end && (cnt_q == LAST_WORD)) begin
                        push  = 1'b1;
                        cnt_d = '0;
`ifdef SAMPLE_UNPACKER_STATS_EN
                        pkt_ok = 1'b1;
`endif
                    end else if (in_packet_end || (cnt_q == LAST_WORD)) begin
                        frame_set = 1'b1;
                        flush     = 1'b1;
                        state_d   = ST_SYNC;
                        cnt_d     = '0;
                    end else begin
                        push  = 1'b1;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
        endcase
    end

    bit_buffer #(
        .BUF_BITS (BUF_BITS)
    ) u_bit_buffer (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush_i   (flush),
        .push_i    (push),
        .word_i    (in_data),
        .ovf_c     (ovf_c),
        .valid_o   (out_valid),
        .samples_o (out_samples)
    );

    // A new error in the same cycle as err_clear keeps the flag set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_SYNC;
            cnt_q       <= '0;
            synced_q    <= 1'b0;
            frame_err_q <= 1'b0;
            ovf_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            synced_q    <= (state_d == ST_RUN);
            frame_err_q <= frame_set | (frame_err_q & ~err_clear);
            ovf_err_q   <= ovf_c | (ovf_err_q & ~err_clear);
        end
    end

    assign synced    = synced_q;
    assign frame_err = frame_err_q;
    assign ovf_err   = ovf_err_q;

`ifdef SAMPLE_UNPACKER_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pkt_cnt_q <= '0;
            smp_cnt_q <= '0;
        end else if (err_clear) begin
            pkt_cnt_q <= '0;
            smp_cnt_q <= '0;
        end else begin
            pkt_cnt_q <= pkt_cnt_q + 16'(pkt_ok);
            smp_cnt_q <= smp_cnt_q + 32'(out_valid);
        end
    end

    assign packet_count = pkt_cnt_q;
    assign sample_count = smp_cnt_q;
`endif

endmodule
